line_code_encoder: RTL
======================

# line_code_encoder

Parametrised, multi-bit-per-clock line encoder for the 100BASE-TX PMA transmit path, sitting between the scrambler/NRZ source and the differential P/N driver. It accepts WIDTH serial bits per clock and emits WIDTH three-level symbols on split P/N rails. Encoding is selectable at run time: NRZ, NRZI or MLT-3. Valid/ready handshakes sit on both sides, the output is registered, and line phase is tracked continuously across beats.

## Interface
- WIDTH, 4: bits (symbols) per beat; bit 0 is transmitted first; legal 1..32.
- COUNT_W, 16: width of the accepted-beat counter.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  2'b00 NRZ, 2'b01 NRZI, 2'b10 MLT-3, 2'b11 reserved (mute); sampled on accept.
- invert  in  1  swap P and N of every symbol; sampled on accept.
- in_data  in  WIDTH  NRZ bits, bit 0 first.
- in_valid  in  1  in_data/mode/invert valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out_p  out  WIDTH  per-symbol positive rail.
- out_n  out  WIDTH  per-symbol negative rail.
- out_valid  out  1  out_p/out_n hold a beat.
- out_ready  in  1  downstream consumes when out_valid && out_ready.
- line_state  out  2  line phase after the last accepted beat.
- beat_count  out  COUNT_W  accepted beats, wraps modulo 2^COUNT_W.

## Operation
- Phase encoding: 0 = zero level (next transition to +), 1 = +, 2 = zero level (next transition to −), 3 = −.
- Symbol levels from phase: phase 1 → {p,n}={1,0}; phase 3 → {0,1}; phase 0 or 2 → {0,0}.
- Bits are processed serially within a beat, bit 0 to bit WIDTH−1.
  - Each symbol reflects the phase *after* that bit is applied.
  - The phase after bit WIDTH−1 is the starting phase for the next beat.
- MLT-3:
  - A 1 advances the phase (0→1→2→3→0).
  - A 0 holds the phase.
- NRZI:
  - A 1 sets phase = (phase==1) ? 3 : 1.
  - A 0 holds the phase.
  - Level is + when phase==1, − otherwise. Phases 0, 2 and 3 all drive {0,1}.
- NRZ:
  - Bit 1 → {1,0}; bit 0 → {0,1}.
  - Phase is unchanged.
- Reserved mode 11: all symbols {0,0}, phase unchanged.
- Mode change:
  - A last_mode register (reset value 2'b10) tracks the mode of the previous accepted beat.
  - If an accepted beat's mode differs from last_mode, phase is forced to 0 before that beat is encoded.
  - last_mode then takes the new value.
- invert:
  - Applied to the encoded symbols for that beat only: out_p and out_n are swapped bitwise.
  - Phase tracking is unaffected by invert.
- Accept rules:
  - On each accept, phase, last_mode, the output register and beat_count update.
  - beat_count increments by 1 and wraps from 2^COUNT_W−1 to 0.
  - Nothing updates without an accept.

## Timing
- Single output register stage. Latency is 1 clock, from the accept edge to out_valid with that beat's symbols.
- in_ready = !reset && (!out_valid || out_ready), combinational. This gives full throughput of one beat per clock while out_ready is held high.
- While out_valid && !out_ready:
  - in_ready = 0.
  - out_p, out_n, out_valid, line_state and beat_count are held stable.
- Simultaneous consume and accept in the same cycle: the register loads the new beat and out_valid stays 1.
- Consume with no accept: out_valid falls to 0 next clock. out_p/out_n are then don't-care, but the implementation keeps them at their last value.
- Reset (synchronous; takes priority over everything, including mid-stall):
  - out_valid=0, out_p=0, out_n=0, line_state=0, beat_count=0, last_mode=2'b10.
  - in_ready=0 during the reset cycle.
  - Any beat in the output register is discarded.

## Test plan
- WIDTH=4, MLT-3, from reset, in_data=4'b1111 → next cycle out_p=4'b0001, out_n=4'b0100, line_state=0; then in_data=4'b0001 → out_p=4'b1111, out_n=4'b0000, line_state=1.
- NRZI from reset (first beat forces phase 0), in_data=4'b0101 → out_p=4'b0011, out_n=4'b1100, line_state=3; NRZ in_data=4'b1010 → out_p=4'b1010, out_n=4'b0101, line_state=0 (mode-change reset).
- invert=1, MLT-3, in_data=4'b1111 from phase 0 → out_p=4'b0100, out_n=4'b0001; line_state=0, identical to the non-inverted case.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, outputs/line_state/beat_count frozen; release → one beat consumed per clock, no beat lost or duplicated, beat_count +1 per accept.
- Wrap: COUNT_W=4, stream 17 beats → beat_count reads 1; mode=2'b11 beat → out_p=out_n=0, line_state unchanged.
- Reset asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, line_state=0, beat_count=0; first post-reset MLT-3 beat 4'b0001 → out_p=4'b1111.

Source files
------------

// File: rtl/line_code_encoder_if.sv
// Beat-level handshake bundle for the line encoder: NRZ bits in, P/N symbol rails out.
// The encoder takes the slave modport; the bit source / line driver side takes master.
interface line_code_encoder_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       mode;
    logic             invert;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_p;
    logic [WIDTH-1:0] out_n;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output mode,
        output invert,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_p,
        input  out_n,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  mode,
        input  invert,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_p,
        output out_n,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/line_code_encoder.sv
// WIDTH-symbol-per-clock NRZ / NRZI / MLT-3 line encoder with one registered output
// stage; line phase carries across beats and resets whenever the encoding mode changes.
module line_code_encoder #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    line_code_encoder_if.slave bus,
    output logic [1:0]         line_state,
    output logic [COUNT_W-1:0] beat_count
);

    typedef enum logic [1:0] {
        PH_ZERO_UP = 2'd0,
        PH_POS     = 2'd1,
        PH_ZERO_DN = 2'd2,
        PH_NEG     = 2'd3
    } phase_t;

    localparam logic [1:0] MODE_NRZ  = 2'b00;
    localparam logic [1:0] MODE_NRZI = 2'b01;
    localparam logic [1:0] MODE_MLT3 = 2'b10;

    logic [WIDTH-1:0]   out_p_reg, out_p_next;
    logic [WIDTH-1:0]   out_n_reg, out_n_next;
    logic               out_valid_reg, out_valid_next;
    phase_t             phase_reg, phase_next;
    logic [1:0]         last_mode_reg, last_mode_next;
    logic [COUNT_W-1:0] beat_count_reg, beat_count_next;

    logic               accept;
    logic               consume;
    phase_t             start_phase;
    logic [2*WIDTH-1:0] phase_chain;
    logic [WIDTH-1:0]   sym_p;
    logic [WIDTH-1:0]   sym_n;
    logic [WIDTH-1:0]   enc_p;
    logic [WIDTH-1:0]   enc_n;

    assign bus.in_ready = !reset && (!out_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = out_valid_reg && bus.out_ready;

    // Serial walk through the beat: slot i of phase_chain holds the phase after bit i.
    always_comb begin : phase_walk
        phase_t ph;
        start_phase = (bus.mode != last_mode_reg) ? PH_ZERO_UP : phase_reg;
        ph          = start_phase;
        phase_chain = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.in_data[i]) begin
                case (bus.mode)
                    MODE_NRZI: ph = (ph == PH_POS) ? PH_NEG : PH_POS;
                    MODE_MLT3: ph = phase_t'(ph + 2'd1);
                    default:   ph = ph;
                endcase
            end
            phase_chain[2*i +: 2] = ph;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sym
            logic [1:0] ph_i;
            logic       sp;
            logic       sn;

            assign ph_i = phase_chain[2*gi +: 2];

            always_comb begin
                sp = 1'b0;
                sn = 1'b0;
                case (bus.mode)
                    MODE_NRZ: begin
                        sp = bus.in_data[gi];
                        sn = !bus.in_data[gi];
                    end
                    // NRZI has only two levels: every non-positive phase drives the low rail.
                    MODE_NRZI: begin
                        sp = (ph_i == PH_POS);
                        sn = (ph_i != PH_POS);
                    end
                    MODE_MLT3: begin
                        sp = (ph_i == PH_POS);
                        sn = (ph_i == PH_NEG);
                    end
                    default: begin
                        sp = 1'b0;
                        sn = 1'b0;
                    end
                endcase
            end

            assign sym_p[gi] = sp;
            assign sym_n[gi] = sn;
            assign enc_p[gi] = bus.invert ? sn : sp;
            assign enc_n[gi] = bus.invert ? sp : sn;
        end
    endgenerate

    always_comb begin
        out_p_next      = out_p_reg;
        out_n_next      = out_n_reg;
        out_valid_next  = out_valid_reg;
        phase_next      = phase_reg;
        last_mode_next  = last_mode_reg;
        beat_count_next = beat_count_reg;
        if (accept) begin
            out_p_next      = enc_p;
            out_n_next      = enc_n;
            out_valid_next  = 1'b1;
            phase_next      = phase_t'(phase_chain[2*WIDTH-2 +: 2]);
            last_mode_next  = bus.mode;
            beat_count_next = beat_count_reg + COUNT_W'(1);
        end else if (consume) begin
            // Rails keep their last value; only the valid flag drops.
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_p_reg      <= '0;
            out_n_reg      <= '0;
            out_valid_reg  <= 1'b0;
            phase_reg      <= PH_ZERO_UP;
            last_mode_reg  <= MODE_MLT3;
            beat_count_reg <= '0;
        end else begin
            out_p_reg      <= out_p_next;
            out_n_reg      <= out_n_next;
            out_valid_reg  <= out_valid_next;
            phase_reg      <= phase_next;
            last_mode_reg  <= last_mode_next;
            beat_count_reg <= beat_count_next;
        end
    end

    assign bus.out_p     = out_p_reg;
    assign bus.out_n     = out_n_reg;
    assign bus.out_valid = out_valid_reg;
    assign line_state    = phase_reg;
    assign beat_count    = beat_count_reg;

endmodule
